// File: rtl/fetch_buffer_pkg.sv
// Shared fetch-buffer types and CPU constants (reset PC, text segment bounds, AdEL code, NOP word).
package fetch_buffer_pkg;

  localparam logic [31:0] PC_RESET     = 32'h0000_3000;
  localparam logic [31:0] FB_TEXT_BASE = 32'h0000_3000;
  localparam logic [31:0] FB_TEXT_TOP  = 32'h0000_6ffc;
  localparam logic [4:0]  EXC_ADEL     = 5'd4;
  localparam logic [31:0] NOP_WORD     = 32'h0000_0000;
  localparam int          FB_DEPTH     = 4;
  localparam int          FB_ENTRY_W   = 65;

  typedef struct packed {
    logic        adel;
    logic [31:0] pc;
    logic [31:0] instr;
  } fb_entry_t;

  function automatic logic addr_exc(input logic [31:0] pc,
                                    input logic [31:0] base,
                                    input logic [31:0] top);
    return (pc[1:0] != 2'b00) || (pc < base) || (pc > top);
  endfunction

endpackage

// File: rtl/fetch_buf_mem.sv
// Fetch-buffer storage: DEPTH x {adel, pc, instr}, one sync write port, one async read port, no reset.
module fetch_buf_mem #(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH),
  parameter int W     = 65
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fetch_buffer.sv
// Instruction prefetch queue between fetch and decode, with per-entry AdEL check.
// Optional same-cycle empty-queue bypass when FETCH_BUF_BYPASS_EN is defined.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int          DEPTH     = FB_DEPTH,
  parameter logic [31:0] TEXT_BASE = FB_TEXT_BASE,
  parameter logic [31:0] TEXT_TOP  = FB_TEXT_TOP
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  input  logic [31:0]             in_pc,
  input  logic [31:0]             in_instr,
  output logic                    in_ready,
  output logic                    out_valid,
  output logic [31:0]             out_pc,
  output logic [31:0]             out_pc8,
  output logic [31:0]             out_instr,
  output logic                    out_exc_adel,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop, bypass, store;
  logic          mem_wr_en;
  logic [PW-1:0] mem_wr_addr;
  fb_entry_t     in_entry, mem_wr_data, rd_entry, head;

  always_comb begin
    in_entry.adel  = addr_exc(in_pc, TEXT_BASE, TEXT_TOP);
    in_entry.pc    = in_pc;
    in_entry.instr = in_entry.adel ? NOP_WORD : in_instr;
  end

  assign in_ready = (count_q != CW'(DEPTH));

  always_comb begin
    push   = in_valid & in_ready;
    pop    = out_ready & (count_q != '0);
    bypass = 1'b0;
`ifdef FETCH_BUF_BYPASS_EN
    bypass = (count_q == '0) & push & out_ready & ~flush;
`endif
    store    = push & ~bypass;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (store) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);
      case ({store, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Reset borrows the write port to zero slot 0 so the idle head reads 0 / 8 / 0.
  always_comb begin
    mem_wr_en   = reset | (store & ~flush);
    mem_wr_addr = reset ? '0 : wr_ptr_q;
    mem_wr_data = reset ? '0 : in_entry;
  end

  fetch_buf_mem #(
    .DEPTH (DEPTH),
    .AW    (PW),
    .W     (FB_ENTRY_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (mem_wr_en),
    .wr_addr (mem_wr_addr),
    .wr_data (mem_wr_data),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_entry)
  );

  always_comb begin
    head      = rd_entry;
    out_valid = (count_q != '0);
`ifdef FETCH_BUF_BYPASS_EN
    if ((count_q == '0) && in_valid) head = in_entry;
    out_valid = (count_q != '0) | in_valid;
`endif
    out_pc       = head.pc;
    out_pc8      = head.pc + 32'd8;
    out_instr    = head.instr;
    out_exc_adel = head.adel;
  end

  assign count = count_q;

endmodule
